// File: rtl/pcie_rx_pkt_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pcie_rx_pkt_fifo
// Brief    : Packet-reservation RX FIFO with reserve/write/commit/read/release
//            pointers. Define PCIE_RX_FIFO_CHK_EN to drop illegal requests and
//            raise sticky err flags.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_rx_pkt_fifo #(
  parameter int P_FIFO_DATA_WIDTH  = 512,
  parameter int P_FIFO_DEPTH_WIDTH = 6,
  parameter int P_LEN_WIDTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_en,
  input  logic [P_LEN_WIDTH-1:0]       alloc_len,
  output logic                         full_n,
  input  logic                         wr_en,
  input  logic [P_FIFO_DATA_WIDTH-1:0] wr_data,
  input  logic                         commit_en,
  input  logic                         rd_en,
  output logic [P_FIFO_DATA_WIDTH-1:0] rd_data,
  input  logic                         free_en,
  input  logic [P_LEN_WIDTH-1:0]       free_len,
  output logic                         empty_n,
  output logic [1:0]                   err
);

  localparam int c_AW = P_FIFO_DEPTH_WIDTH + 1;
  localparam int c_D  = 1 << P_FIFO_DEPTH_WIDTH;
  localparam logic [c_AW-1:0] c_PTR_ONE = {{(c_AW-1){1'b0}}, 1'b1};
  localparam logic [P_FIFO_DEPTH_WIDTH-1:0] c_IDX_ONE = {{(P_FIFO_DEPTH_WIDTH-1){1'b0}}, 1'b1};

  logic [c_AW-1:0] rear_full_q, wr_q, rear_q, front_q, front_empty_q;
  logic [c_AW-1:0] w_alloc_ext, w_free_ext, w_space, w_avail;
  logic            w_alloc_ok, w_wr_ok, w_rd_ok, w_free_ok;
  logic [P_FIFO_DEPTH_WIDTH-1:0] w_rd_idx;

  logic [P_FIFO_DATA_WIDTH-1:0] mem_q [c_D];
  logic [P_FIFO_DATA_WIDTH-1:0] rd_data_q;

  assign w_alloc_ext = {{(c_AW-P_LEN_WIDTH){1'b0}}, alloc_len};
  assign w_free_ext  = {{(c_AW-P_LEN_WIDTH){1'b0}}, free_len};

  // Flipping the wrap bit of front_empty adds D, giving the unreserved count.
  assign w_space = {~front_empty_q[c_AW-1], front_empty_q[c_AW-2:0]} - rear_full_q;
  assign w_avail = rear_q - front_empty_q;
  assign full_n  = (w_space >= w_alloc_ext);
  assign empty_n = (w_avail >= w_free_ext);

`ifdef PCIE_RX_FIFO_CHK_EN
  logic [1:0] err_q;
  logic       w_wr_ovf, w_rd_udf;

  assign w_wr_ovf   = wr_en & (wr_q == rear_full_q);
  assign w_rd_udf   = rd_en & (front_q == rear_q);
  assign w_alloc_ok = alloc_en & full_n;
  assign w_wr_ok    = wr_en & ~w_wr_ovf;
  assign w_rd_ok    = rd_en & ~w_rd_udf;
  assign w_free_ok  = free_en & empty_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 2'b00;
    end else begin
      err_q[0] <= err_q[0] | (alloc_en & ~full_n) | w_wr_ovf;
      err_q[1] <= err_q[1] | w_rd_udf | (free_en & ~empty_n);
    end
  end

  assign err = err_q;
`else
  logic w_unused;

  assign w_alloc_ok = alloc_en;
  assign w_wr_ok    = wr_en;
  assign w_rd_ok    = rd_en;
  assign w_free_ok  = free_en;
  assign err        = 2'b00;
  // Without checking, nothing observes the wrap bit of the read pointer.
  assign w_unused   = front_q[c_AW-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rear_full_q   <= '0;
      wr_q          <= '0;
      rear_q        <= '0;
      front_q       <= '0;
      front_empty_q <= '0;
    end else begin
      if (w_alloc_ok) rear_full_q   <= rear_full_q + w_alloc_ext;
      if (w_wr_ok)    wr_q          <= wr_q + c_PTR_ONE;
      if (commit_en)  rear_q        <= wr_q;
      if (w_rd_ok)    front_q       <= front_q + c_PTR_ONE;
      if (w_free_ok)  front_empty_q <= front_empty_q + w_free_ext;
    end
  end

  // Look-ahead read address keeps rd_data equal to mem[front] with no bubble.
  assign w_rd_idx = w_rd_ok ? (front_q[c_AW-2:0] + c_IDX_ONE) : front_q[c_AW-2:0];

  always_ff @(posedge clk) begin
    if (w_wr_ok) mem_q[wr_q[c_AW-2:0]] <= wr_data;
    rd_data_q <= mem_q[w_rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire
